// File: rtl/uart_pkg.sv
// Shared UART types, data-bits encoding and frame helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // data_bits field: 0..3 selects 5..8 data bits
  typedef enum logic [1:0] {
    DB_5 = 2'd0,
    DB_6 = 2'd1,
    DB_7 = 2'd2,
    DB_8 = 2'd3
  } data_bits_t;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Index of the last data bit in a frame (4..7)
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    return 3'd4 + {1'b0, db};
  endfunction

  // Mask selecting the data bits actually carried by a frame
  function automatic logic [7:0] data_mask(input logic [1:0] db);
    return 8'hFF >> (2'd3 - db);
  endfunction

  // Parity over the carried data bits; odd parity inverts the XOR
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] db,
                                      input logic odd);
    return (^(d & data_mask(db))) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-2 depth, occupancy 0..DEPTH, push accepted when full
// only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write, no reset needed on the array
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// UART core: shared baud tick, TX FSM, oversampling RX FSM, RX FIFO.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div_i,
  input  logic [1:0]  data_bits_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  input  logic        stop2_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_o,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_ONE  = OSW'(1);

  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt >= div_i);

  // Free-running baud tick counter shared by TX and RX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 16'd1;
  end

  // ---------------- TX ----------------
  uart_state_t    tx_state;
  logic [OSW-1:0] tx_os;
  logic [2:0]     tx_idx;
  logic [7:0]     tx_shift;
  data_bits_t     tx_db;
  logic           tx_par_en;
  logic           tx_par_bit;
  logic           tx_stop2;
  logic           tx_bit_end;

  assign tx_ready_o = (tx_state == ST_IDLE);
  assign tx_bit_end = tick && (tx_os == OS_LAST);

  // TX frame sequencer; tx_o is registered and idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= ST_IDLE;
      tx_o       <= 1'b1;
      tx_os      <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_db      <= DB_5;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
    end else begin
      if (tx_state != ST_IDLE && tick) tx_os <= tx_bit_end ? '0 : tx_os + OS_ONE;
      case (tx_state)
        ST_IDLE: begin
          tx_o <= 1'b1;
          if (tx_valid_i) begin
            tx_state   <= ST_START;
            tx_o       <= 1'b0;
            tx_os      <= '0;
            tx_idx     <= '0;
            tx_shift   <= tx_data_i;
            tx_db      <= data_bits_t'(data_bits_i);
            tx_par_en  <= parity_en_i;
            tx_par_bit <= parity_bit(tx_data_i, data_bits_i, parity_odd_i);
            tx_stop2   <= stop2_i;
          end
        end
        ST_START: if (tx_bit_end) begin
          tx_state <= ST_DATA;
          tx_o     <= tx_shift[0];
        end
        ST_DATA: if (tx_bit_end) begin
          if (tx_idx == last_bit_idx(tx_db)) begin
            tx_idx <= '0;
            if (tx_par_en) begin
              tx_state <= ST_PARITY;
              tx_o     <= tx_par_bit;
            end else begin
              tx_state <= ST_STOP;
              tx_o     <= 1'b1;
            end
          end else begin
            tx_idx   <= tx_idx + 3'd1;
            tx_shift <= tx_shift >> 1;
            tx_o     <= tx_shift[1];
          end
        end
        ST_PARITY: if (tx_bit_end) begin
          tx_state <= ST_STOP;
          tx_o     <= 1'b1;
        end
        ST_STOP: if (tx_bit_end) begin
          // tx_idx counts stop bits already sent
          if (tx_stop2 && tx_idx == 3'd0) tx_idx <= 3'd1;
          else tx_state <= ST_IDLE;
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [1:0]     rx_sync;
  logic           rx_s;
  logic           rx_prev;
  uart_state_t    rx_state;
  logic [OSW-1:0] rx_os;
  logic [2:0]     rx_idx;
  logic [7:0]     rx_shift;
  data_bits_t     rx_db;
  logic           rx_par_en;
  logic           rx_par_odd;
  logic           rx_par_got;
  logic           rx_wait_hi;
  logic           rx_mid;
  logic           rx_end;
  logic           stop_sample;
  logic           rx_push;
  logic           rx_pop;
  logic           fifo_full;
  logic           fifo_empty;

  assign rx_s        = rx_sync[1];
  assign rx_mid      = tick && (rx_os == OS_MID);
  assign rx_end      = tick && (rx_os == OS_LAST);
  assign stop_sample = (rx_state == ST_STOP) && !rx_wait_hi && rx_mid;
  assign rx_push     = stop_sample && rx_s;
  assign rx_pop      = rx_valid_o && rx_ready_i;
  assign rx_valid_o  = !fifo_empty;

  assign frame_err_o  = stop_sample && !rx_s;
  assign parity_err_o = rx_push && rx_par_en &&
                        (rx_par_got != parity_bit(rx_shift, rx_db, rx_par_odd));
  assign overrun_o    = rx_push && fifo_full && !rx_pop;

  // Two-flop synchroniser plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '1;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_i};
      rx_prev <= rx_s;
    end
  end

  // RX frame sequencer sampling mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= ST_IDLE;
      rx_os      <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_db      <= DB_5;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_got <= 1'b0;
      rx_wait_hi <= 1'b0;
    end else begin
      if (rx_state != ST_IDLE && tick) rx_os <= rx_end ? '0 : rx_os + OS_ONE;
      case (rx_state)
        ST_IDLE: if (rx_prev && !rx_s) begin
          rx_state   <= ST_START;
          rx_os      <= '0;
          rx_idx     <= '0;
          rx_shift   <= '0;
          rx_db      <= data_bits_t'(data_bits_i);
          rx_par_en  <= parity_en_i;
          rx_par_odd <= parity_odd_i;
          rx_wait_hi <= 1'b0;
        end
        ST_START: begin
          if (rx_mid && rx_s) rx_state <= ST_IDLE;
          else if (rx_end) rx_state <= ST_DATA;
        end
        ST_DATA: begin
          if (rx_mid) rx_shift[rx_idx] <= rx_s;
          if (rx_end) begin
            if (rx_idx == last_bit_idx(rx_db)) rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
            else rx_idx <= rx_idx + 3'd1;
          end
        end
        ST_PARITY: begin
          if (rx_mid) rx_par_got <= rx_s;
          if (rx_end) rx_state <= ST_STOP;
        end
        ST_STOP: begin
          // A low stop bit parks here until the line returns high
          if (rx_wait_hi) begin
            if (rx_s) begin
              rx_state   <= ST_IDLE;
              rx_wait_hi <= 1'b0;
            end
          end else if (rx_mid) begin
            if (rx_s) rx_state <= ST_IDLE;
            else rx_wait_hi <= 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .rdata (rx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: frame-level model of tx_o/tx_ready and
// the RX FIFO contents, plus directed literal checks.
module tb_uart_core;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned OS    = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] div_i;
  logic [1:0]  data_bits_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic        stop2_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        tx_o;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_o;

  logic loop_en;
  logic rx_drv;
  assign rx_i = loop_en ? tx_o : rx_drv;

  uart_core #(
    .FIFO_DEPTH(DEPTH),
    .OVERSAMPLE(OS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_i        (div_i),
    .data_bits_i  (data_bits_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_o         (tx_o),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  logic       exp_tx[$];
  logic [7:0] exp_rx[$];
  int exp_ovr = 0, exp_par = 0, exp_frame = 0;
  int cnt_par = 0, cnt_frame = 0, cnt_ovr = 0;
  logic [7:0] inj_byte;
  int inj_cnt = 0, inj_seen = 0;

  // Per-cycle compare against the frame-level model
  always @(negedge clk) begin
    logic was_ready, exp_bit;
    int nd, ones;
    logic [7:0] mb;
    if (!rst_n) begin
      exp_tx.delete();
      exp_rx.delete();
    end
    was_ready = (exp_tx.size() == 0);
    exp_bit   = was_ready ? 1'b1 : exp_tx.pop_front();
    check("tx_o", tx_o, exp_bit);
    check("tx_ready", tx_ready_o, was_ready);
    if (exp_rx.size() == 0) check("rx_valid_when_empty", rx_valid_o, 0);
    else if (rx_valid_o) begin
      check("rx_data_head", rx_data_o, exp_rx[0]);
      if (rx_ready_i) void'(exp_rx.pop_front());
    end
    if (parity_err_o) cnt_par++;
    if (frame_err_o)  cnt_frame++;
    if (overrun_o)    cnt_ovr++;
    if (inj_seen != inj_cnt) begin
      exp_rx.push_back(inj_byte);
      inj_seen++;
    end
    // A byte offered now is taken at the next rising edge
    if (rst_n && tx_valid_i && was_ready) begin
      nd = 5 + int'(data_bits_i);
      ones = 0;
      mb = '0;
      for (int k = 0; k < OS; k++) exp_tx.push_back(1'b0);
      for (int i = 0; i < nd; i++) begin
        mb[i] = tx_data_i[i];
        if (tx_data_i[i]) ones++;
        for (int k = 0; k < OS; k++) exp_tx.push_back(tx_data_i[i]);
      end
      if (parity_en_i)
        for (int k = 0; k < OS; k++) exp_tx.push_back(((ones % 2) == 1) ^ parity_odd_i);
      for (int k = 0; k < OS * (stop2_i ? 2 : 1); k++) exp_tx.push_back(1'b1);
      if (loop_en) begin
        if (exp_rx.size() < DEPTH) exp_rx.push_back(mb);
        else exp_ovr++;
      end
    end
  end

  // Offer one byte, capture mid-bit tx_o values and count busy cycles
  task automatic send(input logic [7:0] b, input int nbits, output logic [15:0] cap,
                      output int busy);
    @(posedge clk); #1;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    cap  = '0;
    busy = 0;
    for (int c = 0; c < 2000; c++) begin
      if ((c % OS) == OS / 2 && (c / OS) < nbits) cap[c / OS] = tx_o;
      if (tx_ready_o) break;
      busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = v[i];
      repeat (OS) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rx_valid();
    for (int c = 0; c < 400 && !rx_valid_o; c++) begin
      @(posedge clk); #1;
    end
    check("rx_valid_arrives", rx_valid_o, 1);
  endtask

  task automatic check_counts();
    check("parity_err_pulses", cnt_par, exp_par);
    check("frame_err_pulses", cnt_frame, exp_frame);
    check("overrun_pulses", cnt_ovr, exp_ovr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] cap;
    int busy;
    rst_n = 1'b0;
    div_i = '0;
    data_bits_i = 2'd3;
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;
    stop2_i = 1'b0;
    tx_data_i = '0;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    loop_en = 1'b1;
    rx_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_o", tx_o, 1);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_parity_err", parity_err_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overrun", overrun_o, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 loopback of 0x55
    send(8'h55, 10, cap, busy);
    check("frame_55_bits", cap, 16'h02AA);
    check("frame_55_len", busy, 160);
    wait_rx_valid();
    check("rx_55", rx_data_o, 8'h55);
    check_counts();
    rx_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 5 data bits, even parity, 2 stop bits, 0xFF
    data_bits_i = 2'd0;
    parity_en_i = 1'b1;
    stop2_i = 1'b1;
    rx_ready_i = 1'b0;
    send(8'hFF, 9, cap, busy);
    check("frame_5e2_bits", cap, 16'h01FE);
    check("frame_5e2_len", busy, 144);
    wait_rx_valid();
    check("rx_1f", rx_data_o, 8'h1F);
    check_counts();
    rx_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Odd parity expected, even-parity frame driven
    loop_en = 1'b0;
    stop2_i = 1'b0;
    data_bits_i = 2'd3;
    parity_odd_i = 1'b1;
    rx_ready_i = 1'b0;
    inj_byte = 8'h55;
    inj_cnt++;
    exp_par++;
    drive_bits({5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
    repeat (2 * OS) @(posedge clk);
    #1;
    check("rx_par_byte", rx_data_o, 8'h55);
    check_counts();
    rx_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Stop bit driven low: frame error, nothing stored
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;
    exp_frame++;
    drive_bits({6'b0, 1'b0, 8'hA5, 1'b0}, 10);
    repeat (2 * OS) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (2 * OS) @(posedge clk);
    #1;
    check("frame_err_no_valid", rx_valid_o, 0);
    check_counts();

    // Fill FIFO plus one with consumer stalled
    loop_en = 1'b1;
    rx_ready_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 10, cap, busy);
    repeat (OS) @(posedge clk);
    #1;
    check("ovr_head", rx_data_o, 8'h10);
    check("ovr_model_count", exp_ovr, 1);
    check_counts();
    rx_ready_i = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    check("ovr_drained_valid", rx_valid_o, 0);
    check("ovr_drained_all", exp_rx.size(), 0);

    // Two-cycle glitch on the line at div_i=3
    loop_en = 1'b0;
    rx_drv = 1'b1;
    div_i = 16'd3;
    repeat (4) @(posedge clk);
    #1;
    rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_no_valid", rx_valid_o, 0);
    check_counts();
    div_i = 16'd0;
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of a frame
    loop_en = 1'b1;
    @(posedge clk); #1;
    tx_data_i = 8'h00;
    tx_valid_i = 1'b1;
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("mid_frame_tx_low", tx_o, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_tx_o_now", tx_o, 1);
    check("reset_tx_ready_now", tx_ready_o, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("reset_no_partial_push", rx_valid_o, 0);
    check_counts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit (even, >=4).
REQ-003 SHALL have one clock and an asynchronous active-low reset, as the ports below.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 div_i  in  16  baud tick every div_i+1 clk cycles.
REQ-007 data_bits_i  in  2  0..3 selects 5..8 data bits.
REQ-008 parity_en_i / parity_odd_i  in  1 each  parity enable / odd(1) or even(0) parity.
REQ-009 stop2_i  in  1  TX sends 2 stop bits when 1.
REQ-010 tx_data_i  in  8  TX byte, LSB first, upper unused bits ignored.
REQ-011 tx_valid_i / tx_ready_o  in / out  1 each  TX valid-ready handshake.
REQ-012 tx_o  out  1  serial out, idle high.
REQ-013 rx_i  in  1  serial in, asynchronous.
REQ-014 rx_data_o  out  8  FIFO head byte, unused upper bits zero.
REQ-015 rx_valid_o / rx_ready_i  out / in  1 each  RX valid-ready handshake.
REQ-016 parity_err_o, frame_err_o, overrun_o  out  1 each  single-cycle error pulses.

Function
REQ-017 Tick counter SHALL count 0..div_i and pulse tick at wrap; div_i=0 gives tick every cycle; counter runs freely, shared by TX and RX.
REQ-018 rx_i SHALL pass a 2-flop synchroniser (reset value 1) before use.
REQ-019 TX FSM states IDLE, START, DATA, PARITY, STOP; tx_ready_o=1 only in IDLE; transfer on tx_valid_i&tx_ready_o; leaves IDLE the same cycle.
REQ-020 TX SHALL latch byte and all config at accept; config changes mid-frame have no effect.
REQ-021 TX SHALL hold each bit OVERSAMPLE ticks; PARITY skipped when parity_en=0; STOP lasts 1 or 2 bits per stop2; return to IDLE after last stop bit.
REQ-022 Parity bit = XOR of sent data bits, inverted when parity_odd=1.
REQ-023 RX FSM states IDLE, START, DATA, PARITY, STOP; leaves IDLE on synchronised falling edge; config latched there.
REQ-024 RX SHALL sample each bit at tick OVERSAMPLE/2-1 within bit; START sampled high returns to IDLE, no pulses (glitch reject).
REQ-025 RX checks one stop bit only; stop sampled 0 -> byte discarded, frame_err_o pulse, FSM waits for rx high before IDLE.
REQ-026 Parity mismatch -> byte still pushed, parity_err_o pulses in push cycle.
REQ-027 Push occurs in stop-bit sample cycle; rx_valid_o asserts the next cycle.
REQ-028 FIFO full at push -> new byte dropped, FIFO unchanged, overrun_o pulses (parity_err_o still pulses if mismatch).
REQ-029 Pop on rx_valid_o&rx_ready_i; simultaneous push and pop when full SHALL accept both (no overrun).
REQ-030 Pointers wrap at FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH exactly.
REQ-031 RX returns to IDLE after stop sample, ready for a back-to-back start bit.

Reset
REQ-032 On rst_n low: tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, all error pulses 0, FIFO empty, both FSMs IDLE, tick counter 0.
REQ-033 Reset mid-frame SHALL abort both frames immediately; no partial byte pushed.

Structure
REQ-034 Package uart_pkg SHALL hold the shared TX/RX FSM state enum, data-bits encoding and default OVERSAMPLE constant.
REQ-035 RX FIFO SHALL be sub-module uart_rx_fifo (parametrised depth, width 8, full/empty, push/pop).

Verification
REQ-036 div_i=0, 8N1, tx_o looped to rx_i, send 0x55 -> tx_o frame 160 clk, rx_data_o=0x55, no error pulses.
REQ-037 data_bits=0 (5-bit), even parity, 2 stop, send 0xFF -> tx_o 0,11111,1,11; rx_data_o=0x1F.
REQ-038 Odd parity configured on RX, even-parity frame driven -> byte pushed, parity_err_o one pulse.
REQ-039 Drive stop bit 0 -> frame_err_o pulse, rx_valid_o stays 0.
REQ-040 rx_ready_i=0, send FIFO_DEPTH+1 bytes -> first 8 retained in order, overrun_o one pulse on ninth.
REQ-041 2-clk low glitch on rx_i, div_i=3 -> no push, no pulses; rst_n low mid-TX -> tx_o=1 same cycle.
